// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: MULT/MULTU shift-add, DIV/DIVU restoring divide.
// Latency: start sampled at edge N -> busy N+1..N+33 (32 CALC + 1 SIGN), done pulse N+34.
// Backpressure: start is accepted only in IDLE/DONE; start and MTHI/MTLO while busy are dropped.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_x,
  input  logic [31:0] op_y,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        accept;

  // Datapath registers. For multiply {acc_r, q_r} is the 64-bit running
  // product with the multiplier shifting out of q_r; for divide acc_r is the
  // partial remainder and q_r shifts dividend bits out / quotient bits in.
  logic [31:0] acc_r;
  logic [31:0] q_r;
  logic [31:0] m_r;        // multiplicand or divisor magnitude
  logic [31:0] x_raw;      // dividend as presented, returned in hi on divide-by-zero
  logic        is_div_r;
  logic        neg_q_r;    // product / quotient sign
  logic        neg_r_r;    // remainder sign (follows dividend)
  logic        dbz_r;

  // Operand magnitudes at launch
  logic        op_signed;
  logic [31:0] x_mag, y_mag;

  // One radix-2 step
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;

  // Final results produced in SIGN
  logic [63:0] prod_mag;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;

  assign accept = start && (state == S_IDLE || state == S_DONE);

  // Launch-time magnitude conversion for signed ops
  always_comb begin
    op_signed = ~op[0];
    x_mag     = (op_signed && op_x[31]) ? (~op_x + 32'd1) : op_x;
    y_mag     = (op_signed && op_y[31]) ? (~op_y + 32'd1) : op_y;
  end

  // Single iteration arithmetic for multiply and divide
  always_comb begin
    mul_sum   = {1'b0, acc_r} + (q_r[0] ? {1'b0, m_r} : 33'd0);
    div_shift = {acc_r, q_r[31]};
    div_diff  = div_shift - {1'b0, m_r};
  end

  // Sign correction and divide-by-zero override applied in SIGN
  always_comb begin
    prod_mag = {acc_r, q_r};
    prod_fix = neg_q_r ? (~prod_mag + 64'd1) : prod_mag;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div_r) begin
      if (dbz_r) begin
        res_hi = x_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg_r_r ? (~acc_r + 32'd1) : acc_r;
        res_lo = neg_q_r ? (~q_r + 32'd1) : q_r;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (cnt == 6'd31) state_nxt = S_SIGN;
      end
      S_SIGN: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        div_by_zero = dbz_r;
        state_nxt   = start ? S_CALC : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch at launch and one shift step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 6'd0;
      acc_r    <= 32'd0;
      q_r      <= 32'd0;
      m_r      <= 32'd0;
      x_raw    <= 32'd0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dbz_r    <= 1'b0;
    end else if (accept) begin
      cnt      <= 6'd0;
      acc_r    <= 32'd0;
      q_r      <= op[1] ? x_mag : y_mag;
      m_r      <= op[1] ? y_mag : x_mag;
      x_raw    <= op_x;
      is_div_r <= op[1];
      neg_q_r  <= op_signed && (op_x[31] ^ op_y[31]);
      neg_r_r  <= op_signed && op_x[31];
      dbz_r    <= op[1] && (op_y == 32'd0);
    end else if (state == S_CALC) begin
      cnt <= cnt + 6'd1;
      if (is_div_r) begin
        if (!div_diff[32]) begin
          acc_r <= div_diff[31:0];
          q_r   <= {q_r[30:0], 1'b1};
        end else begin
          acc_r <= div_shift[31:0];
          q_r   <= {q_r[30:0], 1'b0};
        end
      end else begin
        acc_r <= mul_sum[32:1];
        q_r   <= {mul_sum[0], q_r[31:1]};
      end
    end
  end

  // HI/LO: result lands in SIGN; MTHI/MTLO only when not busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == S_SIGN) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (!busy) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule
